// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the 32-bit datapath.
// Fetches through PC/MAR/MDR/IR, then walks the execute states chosen by
// the opcode class held in IR. All strobes are forced low while reset is low.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Read,
  output logic        Write,
  output logic        IncPc,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [3:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_HALT, C_REG, C_IMM, C_UNARY, C_MULDIV, C_LDI, C_LD, C_ST
  } iclass_t;

  state_t      state, state_next;
  iclass_t     iclass;
  logic [3:0]  op_sel;
  logic [4:0]  opcode;
  logic        done;
  logic        unused_ir;

  assign opcode    = IR[31:27];
  // Only the opcode field matters here; operand fields go to the datapath.
  assign unused_ir = ^IR[26:0];

  // Classify the opcode and pick the ALU function it needs.
  always_comb begin
    iclass = C_NOP;
    op_sel = 4'b0000;
    case (opcode)
      5'b00000: iclass = C_LD;
      5'b00001: iclass = C_LDI;
      5'b00010: iclass = C_ST;
      5'b00011: begin iclass = C_REG;    op_sel = 4'b0000; end
      5'b00100: begin iclass = C_REG;    op_sel = 4'b0001; end
      5'b00101: begin iclass = C_REG;    op_sel = 4'b1000; end
      5'b00110: begin iclass = C_REG;    op_sel = 4'b1001; end
      5'b00111: begin iclass = C_REG;    op_sel = 4'b0110; end
      5'b01000: begin iclass = C_REG;    op_sel = 4'b0111; end
      5'b01001: begin iclass = C_REG;    op_sel = 4'b0100; end
      5'b01010: begin iclass = C_REG;    op_sel = 4'b0101; end
      5'b01011: begin iclass = C_IMM;    op_sel = 4'b0000; end
      5'b01100: begin iclass = C_IMM;    op_sel = 4'b1000; end
      5'b01101: begin iclass = C_IMM;    op_sel = 4'b1001; end
      5'b01110: begin iclass = C_MULDIV; op_sel = 4'b0010; end
      5'b01111: begin iclass = C_MULDIV; op_sel = 4'b0011; end
      5'b10000: begin iclass = C_UNARY;  op_sel = 4'b1010; end
      5'b10001: begin iclass = C_UNARY;  op_sel = 4'b1011; end
      5'b11001: iclass = C_HALT;
      default:  iclass = C_NOP;
    endcase
  end

  // State register; reset aborts any instruction and restarts at fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_T0;
    else        state <= state_next;
  end

  // Next state and strobes; everything stays at default while reset is low.
  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    Read = 1'b0; Write = 1'b0; IncPc = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0;
    alu_op = 4'b0000;
    run = 1'b1;
    done = 1'b0;
    state_next = state;
    if (reset) begin
      case (state)
        S_T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zin = 1'b1;
          state_next = S_T1;
        end
        S_T1: begin
          Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
          state_next = S_T2;
        end
        S_T2: begin
          MDRout = 1'b1; IRin = 1'b1;
          if (iclass == C_HALT)     state_next = S_HALT;
          else if (iclass == C_NOP) done = 1'b1;
          else                      state_next = S_T3;
        end
        S_T3: begin
          state_next = S_T4;
          case (iclass)
            C_REG, C_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_UNARY: begin Grb = 1'b1; Rout = 1'b1; alu_op = op_sel; Zin = 1'b1; end
            C_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            default: state_next = S_T0;
          endcase
        end
        S_T4: begin
          state_next = S_T5;
          case (iclass)
            C_REG, C_MULDIV: begin
              if (iclass == C_REG) Grc = 1'b1;
              else                 Grb = 1'b1;
              Rout = 1'b1; alu_op = op_sel; Zin = 1'b1;
            end
            C_IMM: begin Cout = 1'b1; alu_op = op_sel; Zin = 1'b1; end
            C_UNARY: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
            C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; end
            default: state_next = S_T0;
          endcase
        end
        S_T5: begin
          state_next = S_T6;
          case (iclass)
            C_REG, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
            C_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
            C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
            default: state_next = S_T0;
          endcase
        end
        S_T6: begin
          state_next = S_T7;
          case (iclass)
            C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
            C_LD: begin Read = 1'b1; MDRin = 1'b1; end
            C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            default: state_next = S_T0;
          endcase
        end
        S_T7: begin
          state_next = S_T0;
          case (iclass)
            C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
            C_ST: begin Write = 1'b1; done = 1'b1; end
            default: state_next = S_T0;
          endcase
        end
        S_HALT: begin
          run = 1'b0;
          state_next = S_HALT;
        end
        default: state_next = S_T0;
      endcase
      // stop is honoured only once the current instruction has finished.
      if (done) state_next = stop ? S_HALT : S_T0;
    end
  end

endmodule
